// File: rtl/player_bullet.sv
// Player projectile: launches on fire, climbs one step per frame, and reports hits/misses.
// Optional macro PLAYER_BULLET_AUTOFIRE_EN makes the launch level-sensitive on fire_i.
module player_bullet #(
    parameter int          num_targets_p     = 8,
    parameter logic [9:0]  speed_p           = 10'd8,
    parameter logic [9:0]  width_p           = 10'd2,
    parameter logic [9:0]  height_p          = 10'd8,
    parameter logic [9:0]  spawn_offset_p    = 10'd19,
    parameter logic [9:0]  top_limit_p       = 10'd9,
    parameter logic [7:0]  cooldown_frames_p = 8'd30,
    parameter logic [11:0] color_p           = 12'hFF0
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       clear_i,
    input  logic                       frame_i,
    input  logic                       fire_i,
    input  logic [9:0]                 player_left_i,
    input  logic [9:0]                 player_top_i,
    input  logic [10*num_targets_p-1:0] tgt_left_i,
    input  logic [10*num_targets_p-1:0] tgt_right_i,
    input  logic [10*num_targets_p-1:0] tgt_top_i,
    input  logic [10*num_targets_p-1:0] tgt_bot_i,
    input  logic [num_targets_p-1:0]   tgt_alive_i,
    output logic                       active_o,
    output logic [9:0]                 left_pos_o,
    output logic [9:0]                 right_pos_o,
    output logic [9:0]                 top_pos_o,
    output logic [9:0]                 bot_pos_o,
    output logic [num_targets_p-1:0]   hit_o,
    output logic                       miss_o,
    output logic [3:0]                 bullet_red_o,
    output logic [3:0]                 bullet_green_o,
    output logic [3:0]                 bullet_blue_o
);
    typedef enum logic [1:0] {
        READY    = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [9:0]               left_reg, left_next;
    logic [9:0]               top_reg, top_next;
    logic [9:0]               right_w, bot_w;
    logic [num_targets_p-1:0] hit_reg, hit_next;
    logic [num_targets_p-1:0] overlap, first_hit;
    logic                     miss_reg, miss_next;
    logic [7:0]               count_reg, count_next;
    logic                     fire_prev_reg;
    logic                     launch;

    assign right_w = left_reg + width_p - 10'd1;
    assign bot_w   = top_reg + height_p - 10'd1;

    generate
        for (genvar gi = 0; gi < num_targets_p; gi++) begin : g_overlap
            logic [9:0] tl, tr, tt, tb;
            assign tl = tgt_left_i[10*gi +: 10];
            assign tr = tgt_right_i[10*gi +: 10];
            assign tt = tgt_top_i[10*gi +: 10];
            assign tb = tgt_bot_i[10*gi +: 10];
            assign overlap[gi] = tgt_alive_i[gi] && (left_reg <= tr) && (right_w >= tl)
                                 && (top_reg <= tb) && (bot_w >= tt);
        end
    endgenerate

    // Two's-complement trick isolates the lowest set bit: lowest index wins.
    assign first_hit = overlap & (-overlap);

`ifdef PLAYER_BULLET_AUTOFIRE_EN
    assign launch = fire_i;
`else
    assign launch = fire_i & ~fire_prev_reg;
`endif

    always_comb begin
        state_next = state_reg;
        left_next  = left_reg;
        top_next   = top_reg;
        count_next = count_reg;
        hit_next   = '0;
        miss_next  = 1'b0;
        case (state_reg)
            READY: begin
                if (launch) begin
                    left_next  = player_left_i + spawn_offset_p;
                    top_next   = player_top_i - height_p;
                    state_next = FLYING;
                end
            end
            FLYING: begin
                // A hit freezes the position, even on a frame cycle.
                if (|overlap) begin
                    hit_next   = first_hit;
                    count_next = 8'd0;
                    state_next = COOLDOWN;
                end else if (frame_i && (top_reg < top_limit_p + speed_p)) begin
                    miss_next  = 1'b1;
                    count_next = 8'd0;
                    state_next = COOLDOWN;
                end else if (frame_i) begin
                    top_next = top_reg - speed_p;
                end
            end
            COOLDOWN: begin
                if (cooldown_frames_p == 8'd0) begin
                    state_next = READY;
                end else if (frame_i) begin
                    count_next = count_reg + 8'd1;
                    if (count_reg == cooldown_frames_p - 8'd1) begin
                        state_next = READY;
                    end
                end
            end
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg     <= READY;
            left_reg      <= '0;
            top_reg       <= '0;
            hit_reg       <= '0;
            miss_reg      <= 1'b0;
            count_reg     <= '0;
            fire_prev_reg <= 1'b0;
        end else if (clear_i) begin
            state_reg     <= READY;
            left_reg      <= '0;
            top_reg       <= '0;
            hit_reg       <= '0;
            miss_reg      <= 1'b0;
            count_reg     <= '0;
            fire_prev_reg <= fire_i;
        end else begin
            state_reg     <= state_next;
            left_reg      <= left_next;
            top_reg       <= top_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
            count_reg     <= count_next;
            fire_prev_reg <= fire_i;
        end
    end

    assign active_o       = (state_reg == FLYING);
    assign left_pos_o     = left_reg;
    assign right_pos_o    = right_w;
    assign top_pos_o      = top_reg;
    assign bot_pos_o      = bot_w;
    assign hit_o          = hit_reg;
    assign miss_o         = miss_reg;
    assign bullet_red_o   = color_p[11:8];
    assign bullet_green_o = color_p[7:4];
    assign bullet_blue_o  = color_p[3:0];
endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: vector table, directed corner sequences, and a randomized run
// against a frame-level reference model of the bullet's life cycle.
module tb_player_bullet;
    localparam int N = 8;

    logic           clk_i = 1'b0;
    logic           reset_ni = 1'b0;
    logic           clear_i = 1'b0;
    logic           frame_i = 1'b0;
    logic           fire_i = 1'b0;
    logic [9:0]     player_left_i = '0;
    logic [9:0]     player_top_i = '0;
    logic [10*N-1:0] tgt_left_i = '0, tgt_right_i = '0, tgt_top_i = '0, tgt_bot_i = '0;
    logic [N-1:0]   tgt_alive_i = '0;
    logic           active_o, miss_o;
    logic [9:0]     left_pos_o, right_pos_o, top_pos_o, bot_pos_o;
    logic [N-1:0]   hit_o;
    logic [3:0]     bullet_red_o, bullet_green_o, bullet_blue_o;

    player_bullet dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .frame_i(frame_i), .fire_i(fire_i),
        .player_left_i(player_left_i), .player_top_i(player_top_i),
        .tgt_left_i(tgt_left_i), .tgt_right_i(tgt_right_i), .tgt_top_i(tgt_top_i),
        .tgt_bot_i(tgt_bot_i), .tgt_alive_i(tgt_alive_i),
        .active_o(active_o), .left_pos_o(left_pos_o), .right_pos_o(right_pos_o),
        .top_pos_o(top_pos_o), .bot_pos_o(bot_pos_o), .hit_o(hit_o), .miss_o(miss_o),
        .bullet_red_o(bullet_red_o), .bullet_green_o(bullet_green_o), .bullet_blue_o(bullet_blue_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: bullet life expressed as phase flags, pixel coordinates
    // and a countdown of remaining cooldown frames.
    bit m_fly, m_cool, m_miss, m_prev;
    int m_x, m_y, m_cd_left, m_hit;

    task automatic model_reset(input bit prev);
        m_fly = 0; m_cool = 0; m_miss = 0; m_prev = prev;
        m_x = 0; m_y = 0; m_cd_left = 0; m_hit = 0;
    endtask

    task automatic model_clock();
        bit launch;
        int found;
        m_hit = 0;
        m_miss = 0;
        if (clear_i) begin
            model_reset(fire_i);
            return;
        end
`ifdef PLAYER_BULLET_AUTOFIRE_EN
        launch = fire_i;
`else
        launch = fire_i && !m_prev;
`endif
        if (!m_fly && !m_cool) begin
            if (launch) begin
                m_x = (int'(player_left_i) + 19) % 1024;
                m_y = (int'(player_top_i) - 8 + 1024) % 1024;
                m_fly = 1;
            end
        end else if (m_fly) begin
            found = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (tgt_alive_i[i] &&
                    m_x <= int'(tgt_right_i[10*i +: 10]) && m_x + 1 >= int'(tgt_left_i[10*i +: 10]) &&
                    m_y <= int'(tgt_bot_i[10*i +: 10]) && m_y + 7 >= int'(tgt_top_i[10*i +: 10]))
                    found = i;
            end
            if (found >= 0) begin
                m_hit = 1 << found;
                m_fly = 0; m_cool = 1; m_cd_left = 30;
            end else if (frame_i && m_y < 9 + 8) begin
                m_miss = 1;
                m_fly = 0; m_cool = 1; m_cd_left = 30;
            end else if (frame_i) begin
                m_y = m_y - 8;
            end
        end else if (frame_i) begin
            m_cd_left--;
            if (m_cd_left == 0) m_cool = 0;
        end
        m_prev = fire_i;
    endtask

    always @(posedge clk_i) if (reset_ni) model_clock();

    always @(negedge clk_i) begin
        logic [50:0] act, exp;
        if (!reset_ni) model_reset(0);
        act = {active_o, left_pos_o, right_pos_o, top_pos_o, bot_pos_o, hit_o, miss_o};
        exp = {m_fly, 10'(m_x), 10'(m_x + 1), 10'(m_y), 10'(m_y + 7), 8'(m_hit), m_miss};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model t=%0t actual=%h required=%h", $time, act, exp);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic frame_pulse(input int n);
        for (int k = 0; k < n; k++) begin
            frame_i = 1;
            tick();
            frame_i = 0;
        end
    endtask

    task automatic do_clear();
        clear_i = 1; fire_i = 0; frame_i = 0;
        tick();
        clear_i = 0;
    endtask

    task automatic launch_at(input logic [9:0] pl, input logic [9:0] pt);
        player_left_i = pl; player_top_i = pt;
        fire_i = 1;
        tick();
        fire_i = 0;
    endtask

    task automatic set_box(input int i, input logic [9:0] l, input logic [9:0] r,
                           input logic [9:0] t, input logic [9:0] b);
        tgt_left_i[10*i +: 10] = l; tgt_right_i[10*i +: 10] = r;
        tgt_top_i[10*i +: 10] = t;  tgt_bot_i[10*i +: 10] = b;
    endtask

    task automatic shot_expect_hit(input logic [N-1:0] alive, input logic [N-1:0] exp_hit, input string tag);
        do_clear();
        tgt_alive_i = alive;
        launch_at(10'd300, 10'd440);
        frame_pulse(26);
        chk({tag, "_top"}, top_pos_o, 224);
        tick();
        chk({tag, "_hit"}, hit_o, exp_hit);
        tick();
        chk({tag, "_hit_gone"}, hit_o, 0);
    endtask

    typedef struct {
        bit         fire;
        bit         frame;
        logic [9:0] pl, pt;
        bit         e_active;
        logic [9:0] e_left, e_top;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 0, 10'd300, 10'd440, 0, 10'd0,   10'd0};
        tbl[1] = '{1, 0, 10'd300, 10'd440, 1, 10'd319, 10'd432};
        tbl[2] = '{1, 1, 10'd300, 10'd440, 1, 10'd319, 10'd424};
        tbl[3] = '{0, 0, 10'd100, 10'd100, 1, 10'd319, 10'd424};
        tbl[4] = '{1, 0, 10'd100, 10'd100, 1, 10'd319, 10'd424};
        tbl[5] = '{0, 1, 10'd100, 10'd100, 1, 10'd319, 10'd416};

        // Reset values
        #2;
        chk("rst_active", active_o, 0);
        chk("rst_right", right_pos_o, 1);
        chk("rst_bot", bot_pos_o, 7);
        chk("rst_hit", hit_o, 0);
        chk("rst_miss", miss_o, 0);
        chk("colour", {bullet_red_o, bullet_green_o, bullet_blue_o}, 12'hFF0);
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1;

        // Launch table
        for (int i = 0; i < 6; i++) begin
            fire_i = tbl[i].fire; frame_i = tbl[i].frame;
            player_left_i = tbl[i].pl; player_top_i = tbl[i].pt;
            tick();
            chk($sformatf("tbl%0d_active", i), active_o, tbl[i].e_active);
            chk($sformatf("tbl%0d_left", i), left_pos_o, tbl[i].e_left);
            chk($sformatf("tbl%0d_right", i), right_pos_o, tbl[i].e_left + 10'd1);
            chk($sformatf("tbl%0d_top", i), top_pos_o, tbl[i].e_top);
            chk($sformatf("tbl%0d_bot", i), bot_pos_o, tbl[i].e_top + 10'd7);
        end
        fire_i = 0; frame_i = 0;

        // Miss, cooldown, dropped fire during cooldown, relaunch
        do_clear();
        tgt_alive_i = '0;
        launch_at(10'd300, 10'd440);
        frame_pulse(52);
        chk("miss_top16", top_pos_o, 16);
        chk("miss_not_yet", miss_o, 0);
        frame_pulse(1);
        chk("miss_pulse", miss_o, 1);
        chk("miss_inactive", active_o, 0);
        tick();
        chk("miss_one_cycle", miss_o, 0);
        fire_i = 1; tick(); fire_i = 0; tick();
        chk("cool_fire_dropped", active_o, 0);
        frame_pulse(29);
        launch_at(10'd300, 10'd440);
        chk("cool_29_blocked", active_o, 0);
        tick();
        frame_pulse(1);
        launch_at(10'd300, 10'd440);
        chk("relaunch", active_o, 1);

        // Hit with coincident frame, priority and alive masking
        for (int i = 0; i < N; i++) set_box(i, 10'd310, 10'd350, 10'd200, 10'd230);
        shot_expect_hit(8'h01, 8'h01, "hit0");
        frame_i = 0;
        do_clear();
        tgt_alive_i = 8'h01;
        launch_at(10'd300, 10'd440);
        frame_pulse(26);
        frame_pulse(1);
        chk("hit_frame_nomove", top_pos_o, 224);
        chk("hit_frame_pulse", hit_o, 8'h01);
        shot_expect_hit(8'h24, 8'h04, "prio");
        shot_expect_hit(8'h20, 8'h20, "alive");
        do_clear();
        tgt_alive_i = '0;
        launch_at(10'd300, 10'd440);
        frame_pulse(53);
        chk("dead_pass_miss", miss_o, 1);
        chk("dead_pass_hit", hit_o, 0);

        // Held fire through a full cycle
        do_clear();
        fire_i = 1;
        player_left_i = 10'd300; player_top_i = 10'd440;
        tick();
        chk("held_launch", active_o, 1);
        frame_pulse(53);
        chk("held_miss", miss_o, 1);
        frame_pulse(30);
        tick();
`ifdef PLAYER_BULLET_AUTOFIRE_EN
        chk("held_relaunch", active_o, 1);
`else
        chk("held_relaunch", active_o, 0);
`endif
        fire_i = 0;

        // Asynchronous reset mid-flight
        do_clear();
        launch_at(10'd300, 10'd440);
        frame_pulse(3);
        reset_ni = 0;
        #1;
        chk("arst_active", active_o, 0);
        chk("arst_left", left_pos_o, 0);
        chk("arst_top", top_pos_o, 0);
        chk("arst_bot", bot_pos_o, 7);
        tick();
        reset_ni = 1;

        // Clear mid-flight coincident with a would-be miss
        tick();
        launch_at(10'd300, 10'd440);
        frame_pulse(52);
        clear_i = 1; frame_i = 1;
        tick();
        clear_i = 0; frame_i = 0;
        chk("clr_active", active_o, 0);
        chk("clr_miss", miss_o, 0);
        chk("clr_top", top_pos_o, 0);
        tick();
        chk("clr_no_late_miss", miss_o, 0);

        // Randomized run checked by the model each cycle
        for (int c = 0; c < 4000; c++) begin
            if (c % 60 == 0) begin
                for (int i = 0; i < N; i++) begin
                    logic [9:0] l, t;
                    l = 10'($urandom_range(250, 400));
                    t = 10'($urandom_range(0, 400));
                    set_box(i, l, l + 10'($urandom_range(0, 40)), t, t + 10'($urandom_range(0, 30)));
                end
                tgt_alive_i = N'($urandom);
                player_left_i = 10'($urandom_range(250, 380));
                player_top_i = 10'($urandom_range(20, 479));
            end
            fire_i = ($urandom_range(0, 2) == 0);
            frame_i = ($urandom_range(0, 2) == 0);
            clear_i = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear_i = 0; fire_i = 0; frame_i = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
